uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Byte-serializing UART transmitter placed directly downstream of the push-button debouncer. It consumes the debounced `transmit` level and fires exactly one 8N1 frame on each rising edge of that level. The frame carries the byte presented on `data`, which is latched at frame start. `txd` drives the board's UART TX pin; `busy` and `done` are available for LEDs and sequencing.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud). Legal range 2..65535. The internal bit-timer width is $clog2(CLKS_PER_BIT).
- `clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `transmit` input, 1 bit: debounced request level, already synchronous to `clk`.
- `data` input, 8 bits: byte to send. Sampled only at frame start.
- `txd` output, 1 bit: serial line, registered. Idles high.
- `busy` output, 1 bit: high while a frame is on the line.
- `done` output, 1 bit: one-cycle pulse after the stop bit completes.

## Operation
- **Reset values** (asserted on any cycle with `rst`=1, including mid-frame): state IDLE, `txd`=1, `busy`=0, `done`=0, bit timer 0, bit index 0, `transmit_d`=1.
  - Because `transmit_d` resets to 1, a button held through reset release never starts a frame. A fresh low-to-high transition is required.
- **Edge detect:** `transmit_d` is updated from `transmit` every cycle, in every state. The start condition is `transmit`=1 and `transmit_d`=0 while the state is IDLE.
  - A rising edge seen outside IDLE is discarded, not queued.
  - Holding `transmit` high produces exactly one frame.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `txd`=1, `busy`=0. On start condition: latch `data` into shift register, clear timer and bit index, go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `txd`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. At each bit end, shift right and increment index. After index 7 completes, go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles, then return to IDLE and assert `done`.
- **Bit timer:** counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. It is never compared against values ≥ CLKS_PER_BIT.
- **Data stability:** changes on `data` after the latch cycle have no effect on the frame in flight.
- **`busy`** is high in START, DATA and STOP.
- **`done`** is high only on the first IDLE cycle after STOP.
- **Back-to-back frames:** a rising edge on that same first-IDLE cycle is accepted. Back-to-back frames are therefore possible with no extra idle bit beyond the stop bit.
- **Reset mid-frame:** `txd` returns high on the next edge. No `done` pulse is issued and the partial frame is abandoned.

## Timing
- Let cycle N be the clock edge at which the start condition is sampled.
- Edge N+1: `txd`=0 and `busy`=1 (start bit begins).
- Data bit k (k=0..7) occupies edges N+1+(k+1)·CLKS_PER_BIT through N+(k+2)·CLKS_PER_BIT.
- The stop bit occupies edges N+1+9·CLKS_PER_BIT through N+10·CLKS_PER_BIT.
- Edge N+10·CLKS_PER_BIT+1: `busy`=0, `done`=1, `txd`=1. The next edge has `done`=0.
- Frame length is exactly 10·CLKS_PER_BIT cycles of `busy`=1.
- Request-to-line latency is 1 cycle after the edge is sampled. The upstream debouncer and synchronizer add their own latency ahead of this block.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
1. **Reset:** hold `rst`=1 for 3 cycles with `transmit`=1. Release with `transmit` still 1 → `txd` stays 1, `busy`=0 indefinitely, no frame.
2. **Single frame:** `data`=8'hA5, pulse `transmit` 0→1 → `txd` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. `busy`=1 for exactly 40 cycles; one `done` pulse on cycle 41.
3. **Held request:** `transmit` held high for 200 cycles with `data`=8'h3C → exactly one frame and one `done`.
4. **Edge during busy / data change:** start a frame with `data`=8'h01. Mid-frame, toggle `transmit` 0→1 and change `data` to 8'hFF → serialized bits are still 1,0,0,0,0,0,0,0 and no second frame follows.
5. **Back-to-back:** raise `transmit` on the `done` cycle with `data`=8'h80 → the second start bit begins the next cycle, giving a 1-bit-wide stop between frames.
6. **Mid-frame reset:** assert `rst` during data bit 3 → `txd`=1, `busy`=0 on the next edge, no `done`. A subsequent edge sends a complete frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : 8N1 UART transmitter; one frame per rising edge of transmit_i.
// Revision : 1.0 - initial release
// ============================================================================

module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int                 TIMER_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         index_q, index_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               transmit_q;

    logic w_bit_end;
    logic w_start;

    assign w_bit_end = (timer_q == BIT_LAST);
    // transmit_q resets high so a request held through reset cannot start a frame
    assign w_start   = (state_q == S_IDLE) && transmit_i && !transmit_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        index_d = index_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    shift_d = data_i;
                    timer_d = '0;
                    index_d = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    timer_d = '0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (index_q == 3'd7) begin
                        index_d = 3'd0;
                        state_d = S_STOP;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the line changes on the same edge as the FSM
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            index_q    <= 3'd0;
            shift_q    <= 8'd0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            transmit_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            index_q    <= index_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            transmit_q <= transmit_i;
        end
    end

    assign txd_o  = txd_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Self-checking bench for uart_tx_frame against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_uart_tx_frame;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       transmit;
    logic [7:0] data;
    logic       txd;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic cap_txd  [0:255];
    logic cap_busy [0:255];
    logic cap_done [0:255];

    always #5 clk = ~clk;

    uart_tx_frame #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .transmit_i (transmit),
        .data_i     (data),
        .txd_o      (txd),
        .busy_o     (busy),
        .done_o     (done)
    );

    // Line level at cycle i of a frame: start bit, 8 data bits LSB first, stop bit
    function automatic logic model_txd(input logic [7:0] d, input int i);
        int b;
        b = i / CPB;
        if (b == 0)
            return 1'b0;
        else if (b <= 8)
            return d[b-1];
        else
            return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the sample just after the edge that sees the rising request
    task automatic start_frame(input logic [7:0] d);
        transmit = 1'b0;
        tick();
        transmit = 1'b1;
        data     = d;
        tick();
    endtask

    task automatic run_capture(input int n, input int drop_at, input int raise_at,
                               input logic [7:0] raise_data, input int rst_at);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            cap_txd[i]  = txd;
            cap_busy[i] = busy;
            cap_done[i] = done;
            if (i == drop_at) transmit = 1'b0;
            if (i == raise_at) begin
                transmit = 1'b1;
                data     = raise_data;
            end
            if (i == rst_at) rst = 1'b1;
            else if (i == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        transmit = 1'b1;
        data     = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({txd, busy, done} !== 3'b100) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got txd/busy/done=%b want 100", i, {txd, busy, done});
            end
        end
        rst = 1'b0;
        run_capture(60, -1, -1, 8'h00, -1);
        for (int i = 0; i < 60; i++) begin
            checks++;
            if ({cap_txd[i], cap_busy[i], cap_done[i]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_release[%0d]: got txd/busy/done=%b want 100", i,
                         {cap_txd[i], cap_busy[i], cap_done[i]});
            end
        end
    endtask

    task automatic test_single_frame();
        start_frame(8'hA5);
        run_capture(FRAME + 2, 5, -1, 8'h00, -1);
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if ({cap_txd[i], cap_busy[i], cap_done[i]} !== {model_txd(8'hA5, i), 2'b10}) begin
                errors++;
                $display("FAIL single[%0d]: got txd/busy/done=%b want %b", i,
                         {cap_txd[i], cap_busy[i], cap_done[i]}, {model_txd(8'hA5, i), 2'b10});
            end
        end
        checks++;
        if ({cap_txd[FRAME], cap_busy[FRAME], cap_done[FRAME]} !== 3'b101) begin
            errors++;
            $display("FAIL single_done: got txd/busy/done=%b want 101",
                     {cap_txd[FRAME], cap_busy[FRAME], cap_done[FRAME]});
        end
        checks++;
        if ({cap_txd[FRAME+1], cap_busy[FRAME+1], cap_done[FRAME+1]} !== 3'b100) begin
            errors++;
            $display("FAIL single_after_done: got txd/busy/done=%b want 100",
                     {cap_txd[FRAME+1], cap_busy[FRAME+1], cap_done[FRAME+1]});
        end
    endtask

    task automatic test_held_request();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        start_frame(8'h3C);
        run_capture(200, -1, -1, 8'h00, -1);
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (cap_txd[i] !== model_txd(8'h3C, i)) begin
                errors++;
                $display("FAIL held_txd[%0d]: got %b want %b", i, cap_txd[i], model_txd(8'h3C, i));
            end
        end
        for (int i = 0; i < 200; i++) begin
            if (cap_busy[i] === 1'b1) busy_cnt++;
            if (cap_done[i] === 1'b1) done_cnt++;
        end
        checks++;
        if (busy_cnt != FRAME || done_cnt != 1 || cap_done[FRAME] !== 1'b1) begin
            errors++;
            $display("FAIL held_count: got busy=%0d done=%0d done@end=%b want busy=%0d done=1 done@end=1",
                     busy_cnt, done_cnt, cap_done[FRAME], FRAME);
        end
        transmit = 1'b0;
    endtask

    task automatic test_data_change();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        start_frame(8'h01);
        run_capture(100, 10, 14, 8'hFF, -1);
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (cap_txd[i] !== model_txd(8'h01, i)) begin
                errors++;
                $display("FAIL datachg_txd[%0d]: got %b want %b", i, cap_txd[i], model_txd(8'h01, i));
            end
        end
        for (int i = 0; i < 100; i++) begin
            if (cap_busy[i] === 1'b1) busy_cnt++;
            if (cap_done[i] === 1'b1) done_cnt++;
        end
        checks++;
        if (busy_cnt != FRAME || done_cnt != 1) begin
            errors++;
            $display("FAIL datachg_count: got busy=%0d done=%0d want busy=%0d done=1",
                     busy_cnt, done_cnt, FRAME);
        end
        transmit = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1;
        d1 = 8'($urandom);
        start_frame(d1);
        run_capture(2 * FRAME + 3, 5, FRAME, 8'h80, -1);
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if ({cap_txd[i], cap_busy[i], cap_done[i]} !== {model_txd(d1, i), 2'b10}) begin
                errors++;
                $display("FAIL b2b_first[%0d]: got %b want %b", i,
                         {cap_txd[i], cap_busy[i], cap_done[i]}, {model_txd(d1, i), 2'b10});
            end
        end
        checks++;
        if ({cap_txd[FRAME], cap_busy[FRAME], cap_done[FRAME]} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_done1: got txd/busy/done=%b want 101",
                     {cap_txd[FRAME], cap_busy[FRAME], cap_done[FRAME]});
        end
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if ({cap_txd[FRAME+1+i], cap_busy[FRAME+1+i], cap_done[FRAME+1+i]} !==
                {model_txd(8'h80, i), 2'b10}) begin
                errors++;
                $display("FAIL b2b_second[%0d]: got %b want %b", i,
                         {cap_txd[FRAME+1+i], cap_busy[FRAME+1+i], cap_done[FRAME+1+i]},
                         {model_txd(8'h80, i), 2'b10});
            end
        end
        checks++;
        if ({cap_busy[2*FRAME+1], cap_done[2*FRAME+1], cap_done[2*FRAME+2]} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_done2: got busy/done/next_done=%b want 010",
                     {cap_busy[2*FRAME+1], cap_done[2*FRAME+1], cap_done[2*FRAME+2]});
        end
        transmit = 1'b0;
    endtask

    task automatic test_midframe_reset();
        logic [7:0] d;
        int         rs;
        d  = 8'($urandom);
        rs = 4 * CPB + 1;
        start_frame(d);
        run_capture(60, 2, -1, 8'h00, rs);
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (i <= rs) begin
                if ({cap_txd[i], cap_busy[i], cap_done[i]} !== {model_txd(d, i), 2'b10}) begin
                    errors++;
                    $display("FAIL rstmid_pre[%0d]: got %b want %b", i,
                             {cap_txd[i], cap_busy[i], cap_done[i]}, {model_txd(d, i), 2'b10});
                end
            end else if ({cap_txd[i], cap_busy[i], cap_done[i]} !== 3'b100) begin
                errors++;
                $display("FAIL rstmid_post[%0d]: got txd/busy/done=%b want 100", i,
                         {cap_txd[i], cap_busy[i], cap_done[i]});
            end
        end
        start_frame(~d);
        run_capture(FRAME + 2, 3, -1, 8'h00, -1);
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if ({cap_txd[i], cap_busy[i]} !== {model_txd(~d, i), 1'b1}) begin
                errors++;
                $display("FAIL rstmid_refr[%0d]: got txd/busy=%b want %b", i,
                         {cap_txd[i], cap_busy[i]}, {model_txd(~d, i), 1'b1});
            end
        end
        checks++;
        if ({cap_busy[FRAME], cap_done[FRAME], cap_done[FRAME+1]} !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_refr_done: got busy/done/next_done=%b want 010",
                     {cap_busy[FRAME], cap_done[FRAME], cap_done[FRAME+1]});
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        for (int f = 0; f < 6; f++) begin
            d = 8'($urandom);
            start_frame(d);
            run_capture(FRAME + 2, $urandom_range(1, 30), -1, 8'h00, -1);
            for (int i = 0; i < FRAME; i++) begin
                checks++;
                if ({cap_txd[i], cap_busy[i], cap_done[i]} !== {model_txd(d, i), 2'b10}) begin
                    errors++;
                    $display("FAIL rand%0d[%0d] data=%h: got %b want %b", f, i, d,
                             {cap_txd[i], cap_busy[i], cap_done[i]}, {model_txd(d, i), 2'b10});
                end
            end
            checks++;
            if ({cap_txd[FRAME], cap_busy[FRAME], cap_done[FRAME], cap_done[FRAME+1]} !== 4'b1010) begin
                errors++;
                $display("FAIL rand%0d_done: got txd/busy/done/next_done=%b want 1010", f,
                         {cap_txd[FRAME], cap_busy[FRAME], cap_done[FRAME], cap_done[FRAME+1]});
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        transmit = 1'b1;
        data     = 8'h00;
        test_reset();
        test_single_frame();
        test_held_request();
        test_data_change();
        test_back_to_back();
        test_midframe_reset();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
